// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with a one-cycle idle gap after every release
// and an optional hold-time limit that forces a release and flags it.
module rr_arbiter16 #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid,
   output logic        timeout
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t      r_state;
   logic [3:0]  r_ptr;
   logic [7:0]  r_cnt;
   logic [15:0] r_gnt;
   logic [3:0]  r_gnt_idx;
   logic        r_gnt_valid;
   logic        r_timeout;

   logic [15:0] w_req_rot;
   logic [3:0]  w_off;
   logic [3:0]  w_win_idx;
   logic        w_normal;
   logic        w_expire;

   // Rotate so that requester r_ptr sits at bit 0; the lowest set bit is the winner.
   assign w_req_rot = (req >> r_ptr) | (req << (5'd16 - {1'b0, r_ptr}));

   always_comb begin
      w_off = 4'd0;
      for (int k = 15; k >= 0; k--) begin
         if (w_req_rot[k]) w_off = 4'(k);
      end
   end

   assign w_win_idx = r_ptr + w_off;
   assign w_normal  = done | ~req[r_gnt_idx];
   // Counter holds (cycles granted - 1), so expiry at TIMEOUT-1 gives exactly TIMEOUT high cycles.
   assign w_expire  = (TIMEOUT != 8'd0) && (r_cnt == TIMEOUT - 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 4'd0;
         r_cnt       <= 8'd0;
         r_gnt       <= 16'd0;
         r_gnt_idx   <= 4'd0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_timeout <= 1'b0;
               if (req != 16'd0) begin
                  r_state     <= ST_BUSY;
                  r_gnt_idx   <= w_win_idx;
                  r_gnt       <= 16'd1 << w_win_idx;
                  r_gnt_valid <= 1'b1;
                  r_cnt       <= 8'd0;
               end
            end
            ST_BUSY: begin
               if (w_normal || w_expire) begin
                  // A normal release coinciding with expiry is not reported as a timeout.
                  r_state     <= ST_IDLE;
                  r_ptr       <= r_gnt_idx + 4'd1;
                  r_gnt       <= 16'd0;
                  r_gnt_idx   <= 4'd0;
                  r_gnt_valid <= 1'b0;
                  r_timeout   <= ~w_normal;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_gnt_idx;
   assign gnt_valid = r_gnt_valid;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: two instances (default limit and limit 4) share stimulus
// and are compared every cycle against a behavioural arbitration model.
module tb_rr_arbiter16;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic        done;

   logic [15:0] gnt_a,  gnt_b;
   logic [3:0]  idx_a,  idx_b;
   logic        val_a,  val_b;
   logic        tmo_a,  tmo_b;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   rr_arbiter16 u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(tmo_a)
   );

   rr_arbiter16 #(.TIMEOUT(8'd4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(tmo_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: whether a grant is held, who holds it, where the next scan starts,
   // how many cycles the grant has been visible, and the forced-release flag.
   typedef struct {
      bit busy;
      int idx;
      int ptr;
      int held;
      bit to;
   } mdl_t;

   mdl_t m_a, m_b;

   function automatic mdl_t mreset();
      mdl_t r;
      r.busy = 0; r.idx = 0; r.ptr = 0; r.held = 0; r.to = 0;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t m, logic [15:0] rq, logic dn, int tlim);
      mdl_t n;
      bit   found;
      bit   normal;
      bit   forced;
      n = m;
      found = 0;
      if (!m.busy) begin
         n.to = 0;
         if (rq != 16'd0) begin
            for (int k = 0; k < 16; k++) begin
               if (!found && rq[(m.ptr + k) % 16]) begin
                  n.idx = (m.ptr + k) % 16;
                  found = 1;
               end
            end
            n.busy = 1;
            n.held = 1;
         end
      end else begin
         normal = dn || !rq[m.idx];
         forced = (tlim != 0) && (m.held == tlim);
         if (normal || forced) begin
            n.busy = 0;
            n.ptr  = (m.idx + 1) % 16;
            n.idx  = 0;
            n.to   = forced && !normal;
         end else begin
            n.held = m.held + 1;
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_gnt"},   32'(gnt_a), m_a.busy ? (32'd1 << m_a.idx) : 32'd0);
      check({tag, "_idx"},   32'(idx_a), m_a.busy ? 32'(m_a.idx) : 32'd0);
      check({tag, "_valid"}, 32'(val_a), 32'(m_a.busy));
      check({tag, "_tmo"},   32'(tmo_a), 32'(m_a.to));
      check({tag, "_gnt4"},  32'(gnt_b), m_b.busy ? (32'd1 << m_b.idx) : 32'd0);
      check({tag, "_idx4"},  32'(idx_b), m_b.busy ? 32'(m_b.idx) : 32'd0);
      check({tag, "_valid4"},32'(val_b), 32'(m_b.busy));
      check({tag, "_tmo4"},  32'(tmo_b), 32'(m_b.to));
      $display("t=%0t %s req=%h done=%b | a: v=%b idx=%0d to=%b | b: v=%b idx=%0d to=%b",
               $time, tag, req, done, val_a, idx_a, tmo_a, val_b, idx_b, tmo_b);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      m_a = mstep(m_a, req, done, 255);
      m_b = mstep(m_b, req, done, 4);
      #1;
      check_all(tag);
   endtask

   // Asserts reset between edges, checks the outputs drop without a clock, releases on negedge.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      m_a = mreset();
      m_b = mreset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int hi;
      rst_n = 1'b0;
      req   = 16'd0;
      done  = 1'b0;
      m_a   = mreset();
      m_b   = mreset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester, then release by done.
      tick("idle");
      req = 16'h0001;
      tick("single_grant");
      check("single_idx0", 32'(idx_a), 32'd0);
      check("single_gnt1", 32'(gnt_a), 32'h1);
      done = 1'b1;
      tick("single_release");
      done = 1'b0;
      req  = 16'h0003;
      tick("ptr_after_release");
      check("ptr_is_1", 32'(idx_a), 32'd1);

      // Full rotation with all requesting, one done per grant.
      do_reset("rst_rot");
      req = 16'hFFFF;
      for (int i = 0; i < 17; i++) begin
         done = 1'b0;
         tick("rot_grant");
         check("rot_seq", 32'(idx_a), 32'(i % 16));
         done = 1'b1;
         tick("rot_release");
         check("rot_gap", 32'(val_a), 32'd0);
      end
      done = 1'b0;

      // Wrap-around scan from ptr=5.
      do_reset("rst_wrap");
      req = 16'h0010;
      tick("wrap_g4");
      done = 1'b1;
      tick("wrap_r4");
      done = 1'b0;
      req  = 16'h0011;
      tick("wrap_g0");
      check("wrap_idx0", 32'(idx_a), 32'd0);
      done = 1'b1;
      tick("wrap_r0");
      done = 1'b0;
      tick("wrap_g4b");
      check("wrap_idx4", 32'(idx_a), 32'd4);

      // Forced release on the limit-4 instance.
      do_reset("rst_to");
      req = 16'h8000;
      tick("to_grant");
      hi = 0;
      while (val_b && hi < 20) begin
         hi++;
         tick("to_hold");
      end
      check("to_high_cycles", 32'(hi), 32'd4);
      check("to_pulse", 32'(tmo_b), 32'd1);
      tick("to_regrant");
      check("to_regrant_valid", 32'(val_b), 32'd1);
      check("to_regrant_idx", 32'(idx_b), 32'd15);
      check("to_pulse_end", 32'(tmo_b), 32'd0);

      // done coinciding with expiry counts as a normal release.
      do_reset("rst_tie");
      tick("tie_grant");
      tick("tie_c2");
      tick("tie_c3");
      tick("tie_c4");
      done = 1'b1;
      tick("tie_release");
      check("tie_valid", 32'(val_b), 32'd0);
      check("tie_tmo", 32'(tmo_b), 32'd0);
      done = 1'b0;

      // Reset mid-grant with a non-zero pointer, then scan must restart at 0.
      do_reset("rst_mid0");
      req = 16'h0100;
      tick("mid_g8");
      done = 1'b1;
      tick("mid_r8");
      done = 1'b0;
      req  = 16'hFFFF;
      tick("mid_g9");
      check("mid_idx9", 32'(idx_a), 32'd9);
      do_reset("mid_reset");
      tick("mid_after");
      check("mid_restart0", 32'(idx_a), 32'd0);
      check("mid_restart0_4", 32'(idx_b), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 3) == 0) req = 16'd1 << $urandom_range(0, 15);
            else req = 16'($urandom);
         end
         done = ($urandom_range(0, 4) == 0);
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, 8-bit: maximum cycles one grant is held; 0 disables the timeout.
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  16  request lines; bit k is requester k.
REQ-005 The block SHALL have port done  input  1  current holder releases the resource.
REQ-006 The block SHALL have port gnt  output  16  one-hot grant vector.
REQ-007 The block SHALL have port gnt_idx  output  4  binary index of the granted requester.
REQ-008 The block SHALL have port gnt_valid  output  1  a grant is active.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-011 In IDLE with req != 0 at a rising edge, the block SHALL enter BUSY on that edge and register the grant (latency 1 cycle).
REQ-012 Winner selection SHALL be round-robin: the first set req bit scanning upward from pointer ptr (4-bit), wrapping 15 -> 0.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with all grant outputs 0.
REQ-014 In BUSY, gnt SHALL equal 1 << gnt_idx, gnt_valid SHALL be 1, and all three SHALL remain stable until release.
REQ-015 In BUSY, release SHALL occur at the edge where done=1, or req[gnt_idx]=0, or the hold counter expires.
REQ-016 On release, the block SHALL go to IDLE, clear gnt, gnt_idx and gnt_valid to 0, and set ptr to gnt_idx+1 mod 16 (15 wraps to 0).
REQ-017 After every release, gnt_valid SHALL be 0 for at least one cycle before the next grant.
REQ-018 The hold counter SHALL be 8-bit, load 0 at grant, and increment each BUSY cycle.
REQ-019 With TIMEOUT != 0 and no other release cause, forced release SHALL occur so that gnt_valid is high for exactly TIMEOUT cycles.
REQ-020 timeout SHALL pulse 1 for exactly one cycle, in the first IDLE cycle after a forced release.
REQ-021 If done=1 (or the req drop) coincides with counter expiry, the release SHALL count as normal, with timeout kept at 0.
REQ-022 done asserted while in IDLE SHALL be ignored.
REQ-023 Changes in req bits other than the holder's during BUSY SHALL NOT affect the grant.
REQ-024 With TIMEOUT=0, the grant SHALL be held indefinitely until done or the holder's req drops.

Reset
REQ-025 When rst_n=0, the block SHALL immediately (without a clock edge) force state IDLE, ptr=0, counter=0, gnt=0, gnt_idx=0, gnt_valid=0 and timeout=0.
REQ-026 Reset asserted mid-grant SHALL drop the grant at once.
REQ-027 The first arbitration after reset release SHALL start its scan at requester 0.

Verification
REQ-028 The bench SHALL check: reset, then req=16'h0001 -> after one edge gnt=16'h0001, gnt_idx=0, gnt_valid=1; done pulse -> next edge gnt_valid=0, ptr=1.
REQ-029 The bench SHALL check: req=16'hFFFF held, done pulsed once per grant -> gnt_idx sequence 0,1,...,15,0 with a one-cycle gap between grants.
REQ-030 The bench SHALL check: after granting 4 (ptr=5), req=16'h0011 -> gnt_idx=0 (wrap), then next grant gnt_idx=4.
REQ-031 The bench SHALL check: TIMEOUT=4, req=16'h8000 held, done=0 -> gnt_valid high exactly 4 cycles, one timeout pulse, then regrant to 15 after one idle cycle.
REQ-032 The bench SHALL check: TIMEOUT=4, done=1 in the 4th grant cycle -> release with timeout=0.
REQ-033 The bench SHALL check: rst_n driven low between clock edges while BUSY -> gnt, gnt_idx, gnt_valid all 0 immediately, and the next grant after reset starts the scan at 0.
